delay_sched: RTL and testbench

- Shared delay-timer scheduler: NREQ requesters contend for one programmable down-counter.
- The winner's delay value is loaded and counted down. The winner then receives a one-cycle done pulse, and the timer is released.
- Sits between client FSMs and the single timer resource, replacing per-client counters.
- Provides an err invariant output for formal checks (must stay 0 in every reachable state).

---
 rtl/delay_sched.sv | 110 +++++++++++
 tb/tb_delay_sched.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_sched.sv
// Shared delay timer: NREQ requesters contend for one down-counter; the winner gets a one-cycle done pulse after its delay.
// Latency: grant 1 cycle after the IDLE sample, done D+2 cycles after it; requests are level-held (req is the backpressure) and losers wait.
// Build option DELAY_SCHED_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module delay_sched #(
    parameter int NREQ    = 4,
    parameter int CBITS   = 14,
    parameter int MAX_DLY = 15000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CBITS-1:0] dly,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] MAXC = CBITS'(MAX_DLY);

    state_t            state;
    logic [CBITS-1:0]  cnt;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     win;
    logic [PW-1:0]     ptr_nxt;
    logic [CBITS-1:0]  win_dly;
    logic [CBITS-1:0]  load;

    // Scan downward so the last hit is the first requester at or above ptr.
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) win = PW'(idx);
        end
    end

    assign win_dly = dly[int'(win)*CBITS +: CBITS];
    assign load    = (win_dly > MAXC) ? MAXC : win_dly;

`ifdef DELAY_SCHED_FIXED_PRIO_EN
    assign ptr_nxt = '0;
`else
    assign ptr_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= (cnt > MAXC) || !$onehot0(gnt) || !$onehot0(done) ||
                   ((gnt != '0) && (state != COUNT)) ||
                   (busy != ((state == COUNT) || (state == DONE)));
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state    <= COUNT;
                        owner    <= win;
                        gnt      <= '0;
                        gnt[win] <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= load;
                    end
                end
                COUNT: begin
                    // An abandon wins over expiry in the same cycle.
                    if (!req[owner]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        ptr   <= ptr_nxt;
                    end else if (cnt == '0) begin
                        state       <= DONE;
                        done[owner] <= 1'b1;
                        gnt         <= '0;
                    end else begin
                        cnt <= cnt - CBITS'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= '0;
                    busy  <= 1'b0;
                    ptr   <= ptr_nxt;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_sched.sv
// Bench for delay_sched: directed scenarios plus random traffic against a timestamp-based reference model.
module tb_delay_sched;
    localparam int NREQ    = 4;
    localparam int CBITS   = 14;
    localparam int MAX_DLY = 15000;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*CBITS-1:0] dly = '0;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  err;

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .MAX_DLY(MAX_DLY)) dut (
        .clk(clk), .rst(rst), .req(req), .dly(dly),
        .gnt(gnt), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: each grant is a set of timestamps derived from the sample cycle.
    int m_own  = -1;
    int m_ptr  = 0;
    int g_beg  = 0;
    int g_end  = -1;
    int d_cyc  = -1;
    int b_end  = -1;
    int free_c = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic set_dly(input int i, input int v);
        dly[i*CBITS +: CBITS] = CBITS'(v);
    endtask

    task automatic model_reset();
        m_own  = -1;
        m_ptr  = 0;
        g_end  = -1;
        d_cyc  = -1;
        b_end  = -1;
        free_c = cyc;
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        logic [2*NREQ-1:0] rot;
        rot = {r, r} >> p;
        for (int j = 0; j < NREQ; j++)
            if (rot[j]) return (p + j) % NREQ;
        return -1;
    endfunction

    task automatic model_sample();
        int w;
        int d;
        if (cyc >= free_c) begin
            if (req != '0) begin
                w     = pick(req, m_ptr);
                d     = int'(dly[w*CBITS +: CBITS]);
                if (d > MAX_DLY) d = MAX_DLY;
                m_own  = w;
                g_beg  = cyc + 1;
                g_end  = cyc + 1 + d;
                d_cyc  = cyc + 2 + d;
                b_end  = d_cyc;
                free_c = cyc + 3 + d;
`ifndef DELAY_SCHED_FIXED_PRIO_EN
                m_ptr  = (w + 1) % NREQ;
`endif
            end
        end else if (m_own >= 0 && cyc >= g_beg && cyc <= g_end && !req[m_own]) begin
            g_end  = cyc;
            b_end  = cyc;
            d_cyc  = -1;
            free_c = cyc + 1;
        end
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ed;
        logic            eb;
        eg = '0;
        ed = '0;
        eb = 1'b0;
        if (m_own >= 0) begin
            if (cyc >= g_beg && cyc <= g_end) eg[m_own] = 1'b1;
            if (cyc == d_cyc) ed[m_own] = 1'b1;
            eb = (cyc >= g_beg && cyc <= b_end);
        end
        chk("gnt",  32'(gnt),  32'(eg));
        chk("done", 32'(done), 32'(ed));
        chk("busy", 32'(busy), 32'(eb));
        chk("err",  32'(err),  32'd0);
    endtask

    task automatic tick();
        model_sample();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int done_seen;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",  32'(gnt),  32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        rst = 1'b1;
        model_reset();

        // Single request, delay 5: done exactly at cycle 7
        req = 4'b0001;
        set_dly(0, 5);
        done_seen = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done[0] === 1'b1 && done_seen < 0) done_seen = k + 1;
            if (k == 6) req = 4'b0000;
        end
        chk("d5_done_cycle", 32'(done_seen), 32'd7);

        // All requesting with zero delay: rotating grants
        for (int i = 0; i < NREQ; i++) set_dly(i, 0);
        req = 4'b1111;
        run(20);
        req = 4'b0000;
        run(4);

        // Oversized delay clamps to the maximum
        req = 4'b0010;
        set_dly(1, 16383);
        run(MAX_DLY + 3);
        req = 4'b0000;
        run(3);

        // Owner 2 abandons three cycles into a count of 10
        set_dly(2, 10);
        set_dly(3, 1);
        set_dly(0, 1);
        req = 4'b0100;
        tick();
        req = 4'b1101;
        run(3);
        req = 4'b1001;
        run(8);
        req = 4'b0000;
        run(4);

        // Reset pulse mid-count, then re-grant with a fresh load
        req = 4'b0001;
        set_dly(0, 12);
        run(5);
        rst = 1'b0;
        #1;
        chk("arst_gnt",  32'(gnt),  32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        chk("arst_hold_gnt", 32'(gnt), 32'd0);
        rst = 1'b1;
        model_reset();
        set_dly(0, 3);
        run(8);
        req = 4'b0000;
        run(3);

        // Delay changed one cycle after the grant is ignored
        req = 4'b0001;
        set_dly(0, 8);
        tick();
        tick();
        set_dly(0, 2);
        run(10);
        req = 4'b0000;
        run(3);

        // Random traffic with abandons and churning delays
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) set_dly(i, $urandom_range(0, 12));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
